vert_host_cmd_link: RTL and testbench

// Host-side peer of the vertical motor CPLD serial link. Packs per-motor move commands into 5-byte

---
 rtl/vert_host_cmd_link_pkg.sv | 44 ++++
 rtl/vert_host_cmd_link_status_decoder.sv | 96 +++++++++
 rtl/vert_host_cmd_link.sv | 157 +++++++++++++++
 tb/tb_vert_host_cmd_link.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vert_host_cmd_link_pkg.sv
// rtl/vert_host_cmd_link_pkg.sv - constants, state types and command packing for the vertical motor link
package vert_host_cmd_link_pkg;

    localparam int NUM_MOTORS = 10;
    localparam int CMD_BYTES  = 5;
    localparam int DIV_LSB    = 4;
    localparam int STEPS_LSB  = 19;
    localparam int DIR_BIT    = 34;

    localparam logic [1:0] TAG_PEND_LO = 2'd0;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_LOAD,
        TX_WAIT_HI,
        TX_WAIT_LO,
        TX_GAP,
        TX_DONE
    } txState_t;

    // State value doubles as the tag expected in the next status byte.
    typedef enum logic [1:0] {
        RX_WAIT_T0,
        RX_WAIT_T1,
        RX_WAIT_T2,
        RX_WAIT_T3
    } rxState_t;

    function automatic logic [8*CMD_BYTES-1:0] packCmd(
        input logic [3:0]  motor,
        input logic [14:0] divider,
        input logic [14:0] steps,
        input logic        dir
    );
        logic [8*CMD_BYTES-1:0] w;
        w                  = '0;
        w[3:0]             = motor;
        w[DIV_LSB +: 15]   = divider;
        w[STEPS_LSB +: 15] = steps;
        w[DIR_BIT]         = dir;
        return w;
    endfunction

endpackage

// File: rtl/vert_host_cmd_link_status_decoder.sv
// rtl/vert_host_cmd_link_status_decoder.sv - CPLD status frame decoder with link timeout
module vert_host_cmd_link_status_decoder
    import vert_host_cmd_link_pkg::*;
#(
    parameter int STATUS_TIMEOUT = 2400000
) (
    input  logic                  CLK_SE_AR,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_ready,
    output logic [NUM_MOTORS-1:0] pending,
    output logic [NUM_MOTORS-1:0] term_hit,
    output logic                  link_up,
    output logic                  status_valid,
    output logic                  status_err,
    output logic                  tag0Seen,
    output logic                  frameCommit
);

    localparam int TW = $clog2(STATUS_TIMEOUT + 1);

    rxState_t       rxState, rxNext;
    logic           rxReadyQ;
    logic           rxEdge;
    logic           tagOk;
    logic           frameErr;
    logic [4:0]     pendLo, pendHi, termLo;
    logic [TW-1:0]  timeoutCnt;

    always_comb begin
        rxNext      = rxState;
        frameCommit = 1'b0;
        frameErr    = 1'b0;
        tag0Seen    = 1'b0;
        rxEdge      = rx_ready & ~rxReadyQ;
        tagOk       = (rx_data[7:6] == 2'(rxState)) && !rx_data[5];
        if (rxEdge) begin
            if (tagOk) begin
                tag0Seen = (rxState == RX_WAIT_T0);
                if (rxState == RX_WAIT_T3) begin
                    rxNext      = RX_WAIT_T0;
                    frameCommit = 1'b1;
                end else begin
                    rxNext = rxState_t'(rxState + 2'd1);
                end
            end else begin
                frameErr = 1'b1;
                // A stray tag0 byte is treated as the start of a new frame.
                if (rx_data[7:6] == TAG_PEND_LO && !rx_data[5]) begin
                    rxNext   = RX_WAIT_T1;
                    tag0Seen = 1'b1;
                end else begin
                    rxNext = RX_WAIT_T0;
                end
            end
        end
    end

    always_ff @(posedge CLK_SE_AR) begin
        if (!rst_n) begin
            rxState      <= RX_WAIT_T0;
            rxReadyQ     <= 1'b0;
            pendLo       <= '0;
            pendHi       <= '0;
            termLo       <= '0;
            pending      <= '0;
            term_hit     <= '0;
            link_up      <= 1'b0;
            status_valid <= 1'b0;
            status_err   <= 1'b0;
            timeoutCnt   <= TW'(STATUS_TIMEOUT);
        end else begin
            rxState      <= rxNext;
            rxReadyQ     <= rx_ready;
            status_valid <= frameCommit;
            status_err   <= frameErr;
            if (tag0Seen)
                pendLo <= rx_data[4:0];
            if (rxEdge && tagOk && rxState == RX_WAIT_T1)
                pendHi <= rx_data[4:0];
            if (rxEdge && tagOk && rxState == RX_WAIT_T2)
                termLo <= rx_data[4:0];
            if (frameCommit) begin
                pending    <= {pendHi, pendLo};
                term_hit   <= {rx_data[4:0], termLo};
                link_up    <= 1'b1;
                timeoutCnt <= TW'(STATUS_TIMEOUT);
            end else if (timeoutCnt != '0) begin
                timeoutCnt <= timeoutCnt - TW'(1);
            end else begin
                link_up <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/vert_host_cmd_link.sv
// rtl/vert_host_cmd_link.sv - host side of the vertical motor CPLD link: command framing and slot locks
module vert_host_cmd_link
    import vert_host_cmd_link_pkg::*;
#(
    parameter int BYTE_GAP       = 16,
    parameter int BYTE_CYCLES    = 2083,
    parameter int STATUS_TIMEOUT = 2400000
) (
    input  logic                  CLK_SE_AR,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_motor,
    input  logic [14:0]           cmd_divider,
    input  logic [14:0]           cmd_steps,
    input  logic                  cmd_dir,
    output logic                  cmd_err,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_busy,
    input  logic [7:0]            rx_data,
    input  logic                  rx_ready,
    output logic [NUM_MOTORS-1:0] pending,
    output logic [NUM_MOTORS-1:0] term_hit,
    output logic [NUM_MOTORS-1:0] slot_free,
    output logic                  link_up,
    output logic                  status_valid,
    output logic                  status_err
);

    localparam int GW = $clog2(BYTE_GAP + 1);
    localparam int AW = $clog2(BYTE_CYCLES + 1);

    txState_t                txState, txNext;
    logic [8*CMD_BYTES-1:0]  cmdWord;
    logic [2:0]              byteIdx;
    logic [GW-1:0]           gapCnt;
    logic [3:0]              txMotor;
    logic                    motorBad;
    logic                    cmdAccept;
    logic [15:0]             slotFreeWide;
    logic                    tag0Seen;
    logic                    frameCommit;
    logic [NUM_MOTORS-1:0]   lock, lockNext;
    logic [NUM_MOTORS-1:0]   doneSeen, doneNext;
    logic [NUM_MOTORS-1:0]   qual, qualNext;
    logic [NUM_MOTORS-1:0]   ageReached;
    logic [AW-1:0]           age [NUM_MOTORS];

    vert_host_cmd_link_status_decoder #(
        .STATUS_TIMEOUT(STATUS_TIMEOUT)
    ) u_status (
        .CLK_SE_AR    (CLK_SE_AR),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .pending      (pending),
        .term_hit     (term_hit),
        .link_up      (link_up),
        .status_valid (status_valid),
        .status_err   (status_err),
        .tag0Seen     (tag0Seen),
        .frameCommit  (frameCommit)
    );

    assign slot_free    = {NUM_MOTORS{link_up}} & ~pending & ~lock;
    assign slotFreeWide = {{(16-NUM_MOTORS){1'b0}}, slot_free};
    assign motorBad     = cmd_motor >= 4'(NUM_MOTORS);
    assign cmd_ready    = (txState == TX_IDLE) && (motorBad || slotFreeWide[cmd_motor]);
    assign cmdAccept    = cmd_valid && cmd_ready;
    assign tx_data      = cmdWord[{byteIdx, 3'b000} +: 8];
    assign txMotor      = cmdWord[3:0];

    always_comb begin
        txNext   = txState;
        tx_start = 1'b0;
        case (txState)
            TX_IDLE:    if (cmdAccept && !motorBad) txNext = TX_LOAD;
            TX_LOAD: begin
                tx_start = 1'b1;
                txNext   = TX_WAIT_HI;
            end
            TX_WAIT_HI: if (tx_busy) txNext = TX_WAIT_LO;
            TX_WAIT_LO: if (!tx_busy) txNext = TX_GAP;
            TX_GAP:
                if (gapCnt == GW'(BYTE_GAP - 1))
                    txNext = (byteIdx == 3'(CMD_BYTES - 1)) ? TX_DONE : TX_LOAD;
            TX_DONE:    txNext = TX_IDLE;
            default:    txNext = TX_IDLE;
        endcase
    end

    // A lock is released only by a frame whose tag0 byte left the CPLD after it
    // could have seen our command, i.e. BYTE_CYCLES or more after the last byte finished.
    always_comb begin
        lockNext   = lock;
        doneNext   = doneSeen;
        qualNext   = qual;
        ageReached = '0;
        for (int m = 0; m < NUM_MOTORS; m++)
            ageReached[m] = (age[m] >= AW'(BYTE_CYCLES));
        if (tag0Seen)
            qualNext = lock & doneSeen & ageReached;
        if (frameCommit) begin
            lockNext = lock & ~qual;
            doneNext = doneSeen & ~qual;
            qualNext = '0;
        end
        for (int m = 0; m < NUM_MOTORS; m++) begin
            if (txState == TX_DONE && txMotor == 4'(m))
                doneNext[m] = 1'b1;
            if (cmdAccept && !motorBad && cmd_motor == 4'(m)) begin
                lockNext[m] = 1'b1;
                doneNext[m] = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK_SE_AR) begin
        if (!rst_n) begin
            txState  <= TX_IDLE;
            cmdWord  <= '0;
            byteIdx  <= '0;
            gapCnt   <= '0;
            cmd_err  <= 1'b0;
            lock     <= '0;
            doneSeen <= '0;
            qual     <= '0;
            for (int m = 0; m < NUM_MOTORS; m++)
                age[m] <= '0;
        end else begin
            txState  <= txNext;
            cmd_err  <= cmdAccept && motorBad;
            lock     <= lockNext;
            doneSeen <= doneNext;
            qual     <= qualNext;
            if (cmdAccept && !motorBad) begin
                cmdWord <= packCmd(cmd_motor, cmd_divider, cmd_steps, cmd_dir);
                byteIdx <= '0;
            end
            if (txState == TX_GAP)
                gapCnt <= gapCnt + GW'(1);
            else
                gapCnt <= '0;
            if (txState == TX_GAP && txNext == TX_LOAD)
                byteIdx <= byteIdx + 3'd1;
            // age[m] equals cycles elapsed since the DONE cycle of motor m's last command.
            for (int m = 0; m < NUM_MOTORS; m++) begin
                if (txState == TX_DONE && txMotor == 4'(m))
                    age[m] <= AW'(1);
                else if (age[m] != AW'(BYTE_CYCLES))
                    age[m] <= age[m] + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_vert_host_cmd_link.sv
// tb/tb_vert_host_cmd_link.sv - scoreboard bench: UART byte model, CPLD status model, command framing and locks
module tb_vert_host_cmd_link;

    localparam int BYTE_GAP       = 4;
    localparam int BYTE_CYCLES    = 40;
    localparam int STATUS_TIMEOUT = 3000;

    logic        CLK_SE_AR = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_motor = '0;
    logic [14:0] cmd_divider = '0;
    logic [14:0] cmd_steps = '0;
    logic        cmd_dir = 1'b0;
    logic        cmd_err;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_ready = 1'b0;
    logic [9:0]  pending;
    logic [9:0]  term_hit;
    logic [9:0]  slot_free;
    logic        link_up;
    logic        status_valid;
    logic        status_err;

    int          nChecks = 0;
    int          nPass = 0;
    int          validCnt = 0;
    int          errCnt = 0;
    logic [7:0]  txExpQ[$];
    logic [19:0] statQ[$];

    vert_host_cmd_link #(
        .BYTE_GAP(BYTE_GAP),
        .BYTE_CYCLES(BYTE_CYCLES),
        .STATUS_TIMEOUT(STATUS_TIMEOUT)
    ) dut (
        .CLK_SE_AR    (CLK_SE_AR),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_motor    (cmd_motor),
        .cmd_divider  (cmd_divider),
        .cmd_steps    (cmd_steps),
        .cmd_dir      (cmd_dir),
        .cmd_err      (cmd_err),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_busy      (tx_busy),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .pending      (pending),
        .term_hit     (term_hit),
        .slot_free    (slot_free),
        .link_up      (link_up),
        .status_valid (status_valid),
        .status_err   (status_err)
    );

    always #5 CLK_SE_AR = ~CLK_SE_AR;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // UART transmitter model: busy for BYTE_CYCLES after each start strobe.
    initial begin
        int busyLeft;
        int idle;
        logic [7:0] expByte;
        busyLeft = 0;
        idle = 0;
        forever begin
            @(negedge CLK_SE_AR);
            if (tx_start === 1'b1) begin
                if (txExpQ.size() == 0) begin
                    checkEq("tx_unexpected", {56'd0, tx_data}, 64'hFFFF);
                end else begin
                    if ((txExpQ.size() % 5) != 0)
                        checkEq("tx_gap_ge", 64'(idle >= BYTE_GAP), 64'd1);
                    expByte = txExpQ.pop_front();
                    checkEq("tx_byte", {56'd0, tx_data}, {56'd0, expByte});
                end
                tx_busy = 1'b1;
                busyLeft = BYTE_CYCLES;
                idle = 0;
            end else if (busyLeft > 0) begin
                busyLeft--;
                if (busyLeft == 0) tx_busy = 1'b0;
            end else begin
                idle++;
            end
        end
    end

    // Status output scoreboard.
    initial begin
        logic [19:0] exp;
        forever begin
            @(negedge CLK_SE_AR);
            if (status_err === 1'b1) errCnt++;
            if (status_valid === 1'b1) begin
                validCnt++;
                if (statQ.size() == 0) begin
                    checkEq("stat_unexpected", {44'd0, pending, term_hit}, 64'hFFFFF);
                end else begin
                    exp = statQ.pop_front();
                    checkEq("stat_pending", {54'd0, pending}, {54'd0, exp[19:10]});
                    checkEq("stat_term", {54'd0, term_hit}, {54'd0, exp[9:0]});
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic sendByte(input logic [7:0] b);
        @(negedge CLK_SE_AR);
        rx_data = b;
        rx_ready = 1'b1;
        repeat (2) @(negedge CLK_SE_AR);
        rx_ready = 1'b0;
        repeat (2) @(negedge CLK_SE_AR);
    endtask

    task automatic sendFrame(input logic [9:0] pend, input logic [9:0] term);
        statQ.push_back({pend, term});
        sendByte({2'd0, 1'b0, pend[4:0]});
        sendByte({2'd1, 1'b0, pend[9:5]});
        sendByte({2'd2, 1'b0, term[4:0]});
        sendByte({2'd3, 1'b0, term[9:5]});
    endtask

    task automatic pushCmdBytes(input logic [3:0] m, input logic [14:0] d, input logic [14:0] s, input logic dr);
        logic [39:0] w;
        w = {5'd0, dr, s, d, m};
        for (int i = 0; i < 5; i++) txExpQ.push_back(w[i*8 +: 8]);
    endtask

    // Returns on the negedge following the accepting clock edge.
    task automatic issueCmd(input logic [3:0] m, input logic [14:0] d, input logic [14:0] s, input logic dr,
                            output int waited);
        @(negedge CLK_SE_AR);
        cmd_motor = m;
        cmd_divider = d;
        cmd_steps = s;
        cmd_dir = dr;
        cmd_valid = 1'b1;
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 200) begin
            @(negedge CLK_SE_AR);
            waited++;
        end
        if (waited >= 200) checkEq("cmd_accept_timeout", 64'(waited), 64'd0);
        @(negedge CLK_SE_AR);
        cmd_valid = 1'b0;
    endtask

    task automatic waitTxDrain();
        int n;
        n = 0;
        while (txExpQ.size() != 0 && n < 2000) begin
            @(negedge CLK_SE_AR);
            n++;
        end
        checkEq("tx_drain", 64'(txExpQ.size()), 64'd0);
    endtask

    initial begin
        int waited;
        int errBase;
        int n;

        repeat (5) @(negedge CLK_SE_AR);
        checkEq("reset_outputs", {tx_start, cmd_err, cmd_ready, link_up, status_valid, status_err,
                                  pending, term_hit, slot_free, tx_data}, 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge CLK_SE_AR);
        checkEq("post_reset_link", {63'd0, link_up}, 64'd0);

        sendFrame(10'h000, 10'h000);
        checkEq("first_link_up", {63'd0, link_up}, 64'd1);
        checkEq("first_slot_free", {54'd0, slot_free}, 64'h3FF);
        checkEq("first_valid_cnt", 64'(validCnt), 64'd1);

        txExpQ.push_back(8'h33); txExpQ.push_back(8'h12); txExpQ.push_back(8'h28);
        txExpQ.push_back(8'h02); txExpQ.push_back(8'h04);
        issueCmd(4'd3, 15'h0123, 15'h0045, 1'b1, waited);
        checkEq("m3_ready_wait", 64'(waited), 64'd0);
        checkEq("m3_locked", {54'd0, slot_free}, 64'h3F7);
        waitTxDrain();
        sendFrame(10'h000, 10'h000);
        checkEq("early_frame_keeps_lock", {54'd0, slot_free}, 64'h3F7);
        repeat (100) @(negedge CLK_SE_AR);
        sendFrame(10'h008, 10'h000);
        checkEq("cpld_pending_m3", {54'd0, slot_free}, 64'h3F7);
        sendFrame(10'h000, 10'h000);
        checkEq("m3_released", {54'd0, slot_free}, 64'h3FF);

        errBase = errCnt;
        sendByte(8'h00);
        sendByte(8'h80);
        checkEq("err_pulse_cnt", 64'(errCnt - errBase), 64'd1);
        checkEq("err_outputs_hold", {44'd0, pending, term_hit}, 64'd0);
        sendFrame(10'h028, 10'h01F);
        checkEq("frame_pending", {54'd0, pending}, 64'h028);
        checkEq("frame_term", {54'd0, term_hit}, 64'h01F);
        checkEq("frame_slot_free", {54'd0, slot_free}, 64'h3D7);

        errBase = errCnt;
        statQ.push_back({10'h020, 10'h000});
        sendByte(8'h00);
        sendByte(8'h00);
        sendByte(8'h41);
        sendByte(8'h80);
        sendByte(8'hC0);
        checkEq("restart_err_cnt", 64'(errCnt - errBase), 64'd1);
        checkEq("restart_pending", {54'd0, pending}, 64'h020);

        issueCmd(4'd12, 15'h7FFF, 15'h1234, 1'b0, waited);
        checkEq("bad_motor_ready_wait", 64'(waited), 64'd0);
        checkEq("bad_motor_err", {63'd0, cmd_err}, 64'd1);
        @(negedge CLK_SE_AR);
        checkEq("bad_motor_err_pulse", {63'd0, cmd_err}, 64'd0);
        repeat (10) @(negedge CLK_SE_AR);

        cmd_motor = 4'd0;
        repeat (STATUS_TIMEOUT + 20) @(negedge CLK_SE_AR);
        checkEq("timeout_link", {63'd0, link_up}, 64'd0);
        checkEq("timeout_slot_free", {54'd0, slot_free}, 64'd0);
        checkEq("timeout_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        checkEq("timeout_pending_hold", {54'd0, pending}, 64'h020);
        sendFrame(10'h000, 10'h000);
        checkEq("relink", {63'd0, link_up}, 64'd1);
        checkEq("relink_cmd_ready", {63'd0, cmd_ready}, 64'd1);

        pushCmdBytes(4'd5, 15'h2AAA, 15'h0155, 1'b0);
        issueCmd(4'd5, 15'h2AAA, 15'h0155, 1'b0, waited);
        checkEq("m5_locked", {54'd0, slot_free}, 64'h3DF);
        n = 0;
        while (txExpQ.size() > 3 && n < 1000) begin
            @(negedge CLK_SE_AR);
            n++;
        end
        checkEq("m5_byte2_started", 64'(txExpQ.size()), 64'd3);
        repeat (5) @(negedge CLK_SE_AR);
        txExpQ.delete();
        rst_n = 1'b0;
        @(negedge CLK_SE_AR);
        checkEq("midframe_reset_outputs", {tx_start, cmd_err, cmd_ready, link_up, status_valid, status_err,
                                           pending, term_hit, slot_free, tx_data}, 64'd0);
        repeat (20) @(negedge CLK_SE_AR);
        rst_n = 1'b1;
        repeat (60) @(negedge CLK_SE_AR);
        sendFrame(10'h000, 10'h000);
        checkEq("reset_cleared_lock", {54'd0, slot_free}, 64'h3FF);

        repeat (10) @(negedge CLK_SE_AR);
        checkEq("stat_queue_empty", 64'(statQ.size()), 64'd0);
        checkEq("tx_queue_empty", 64'(txExpQ.size()), 64'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
